per_gen: RTL and testbench

//   Programmable square-wave generator; the transmit-side companion of the period counter.
//   On a start pulse it latches a period in ms and a repeat count, then drives o_signal
//   as a 50%-duty square wave for that many full periods. It then pulses o_done.

---
 rtl/per_gen.sv | 121 ++++++++++++
 tb/tb_per_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/per_gen.sv
// Programmable square-wave burst generator: after an accepted start, emits i_count
// full 50%-duty periods of i_period ms on o_signal, then pulses o_done for one cycle.
module per_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [9:0] i_period,
    input  logic [7:0] i_count,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_signal,
    output logic [1:0] o_dbg_state
);

    localparam int HALF_MS = CLK_FREQ / 2000;
    localparam int TW      = (HALF_MS > 1) ? $clog2(HALF_MS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(HALF_MS - 1);

    // Handshake: o_ready is high only in idle; a start is accepted on a clock edge
    // where i_start && o_ready. Starts at any other time are dropped, never queued.
    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_high = 2'd1,
        e_low  = 2'd2,
        e_done = 2'd3
    } state_t;

    state_t        r_state, state_nxt;
    logic [TW-1:0] r_tick, tick_nxt;
    logic [9:0]    r_half, half_nxt;
    logic [9:0]    r_period, period_nxt;
    logic [7:0]    r_left, left_nxt;
    logic          r_signal, signal_nxt;
    logic          phase_end;
    logic [7:0]    left_dec;

    assign phase_end = (r_tick == TICK_MAX) && (r_half == (r_period - 10'd1));
    assign left_dec  = r_left - 8'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= e_idle;
            r_tick   <= '0;
            r_half   <= '0;
            r_period <= '0;
            r_left   <= '0;
            r_signal <= 1'b0;
        end else begin
            r_state  <= state_nxt;
            r_tick   <= tick_nxt;
            r_half   <= half_nxt;
            r_period <= period_nxt;
            r_left   <= left_nxt;
            r_signal <= signal_nxt;
        end
    end

    always_comb begin
        state_nxt  = r_state;
        tick_nxt   = r_tick;
        half_nxt   = r_half;
        period_nxt = r_period;
        left_nxt   = r_left;
        signal_nxt = 1'b0;
        case (r_state)
            e_idle: begin
                if (i_start) begin
                    period_nxt = i_period;
                    left_nxt   = i_count;
                    tick_nxt   = '0;
                    half_nxt   = '0;
                    if ((i_period == 10'd0) || (i_count == 8'd0)) begin
                        state_nxt = e_done;
                    end else begin
                        state_nxt  = e_high;
                        signal_nxt = 1'b1;
                    end
                end
            end
            e_high, e_low: begin
                signal_nxt = (r_state == e_high);
                if (phase_end) begin
                    tick_nxt = '0;
                    half_nxt = '0;
                    if (r_state == e_high) begin
                        state_nxt  = e_low;
                        signal_nxt = 1'b0;
                    end else begin
                        left_nxt = left_dec;
                        if (left_dec == 8'd0) begin
                            state_nxt  = e_done;
                            signal_nxt = 1'b0;
                        end else begin
                            state_nxt  = e_high;
                            signal_nxt = 1'b1;
                        end
                    end
                end else if (r_tick == TICK_MAX) begin
                    tick_nxt = '0;
                    half_nxt = r_half + 10'd1;
                end else begin
                    tick_nxt = r_tick + 1'b1;
                end
            end
            e_done: begin
                state_nxt = e_idle;
            end
            default: begin
                state_nxt = e_idle;
            end
        endcase
    end

    assign o_ready     = (r_state == e_idle);
    assign o_done      = (r_state == e_done);
    assign o_signal    = r_signal;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_per_gen.sv
// Bench for per_gen: each burst's cycle-by-cycle {ready,done,signal} trace is
// generated from the period/count rules and compared sample by sample.
module tb_per_gen;

    localparam int CLK_FREQ = 20_000;
    localparam int HALF_MS  = CLK_FREQ / 2000;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [9:0] i_period = '0;
    logic [7:0] i_count = '0;
    logic       o_ready;
    logic       o_done;
    logic       o_signal;
    logic [1:0] o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    per_gen #(.CLK_FREQ(CLK_FREQ)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_period(i_period),
        .i_count(i_count),
        .o_ready(o_ready),
        .o_done(o_done),
        .o_signal(o_signal),
        .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference trace, one {ready,done,signal} entry per cycle after start is sampled.
    task automatic build_exp(input int p, input int c, input bit start_in_done);
        exp_q.delete();
        if (p != 0 && c != 0) begin
            for (int k = 0; k < c; k++) begin
                for (int j = 0; j < p * HALF_MS; j++) exp_q.push_back(3'b001);
                for (int j = 0; j < p * HALF_MS; j++) exp_q.push_back(3'b000);
            end
        end
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        if (start_in_done) exp_q.push_back(3'b100);
    endtask

    // Called mid-cycle in idle; returns mid-cycle in idle, so consecutive calls are back-to-back.
    task automatic run_burst(input int p, input int c, input int busy_at,
                             input bit start_in_done, input int abort_at);
        int idx = 0;
        int last_rise = -1;
        logic prev_sig = 1'b0;
        logic [2:0] e;
        build_exp(p, c, start_in_done);
        i_period = 10'(p);
        i_count  = 8'(c);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        i_period = 10'($urandom);
        i_count  = 8'($urandom);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("burst", {29'd0, o_ready, o_done, o_signal}, {29'd0, e});
            if (o_signal && !prev_sig) begin
                if (last_rise >= 0) check("period", idx - last_rise, 2 * p * HALF_MS);
                last_rise = idx;
            end
            prev_sig = o_signal;
            if (idx == abort_at) begin
                i_rst_n = 1'b0;
                #1;
                check("rst_async", {29'd0, o_ready, o_done, o_signal}, 32'b100);
                #2;
                i_rst_n = 1'b1;
                tick();
                check("rst_idle", {29'd0, o_ready, o_done, o_signal}, 32'b100);
                return;
            end
            i_start = (idx == busy_at) || (start_in_done && e == 3'b010);
            if (i_start) begin
                i_period = 10'($urandom_range(1, 1023));
                i_count  = 8'($urandom_range(1, 255));
            end
            idx++;
            if (exp_q.size() > 0) tick();
        end
        i_start = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_out", {29'd0, o_ready, o_done, o_signal}, 32'b100);
        check("reset_state", o_dbg_state, 0);
        #10;
        i_rst_n = 1'b1;
        tick();
        check("post_reset", {29'd0, o_ready, o_done, o_signal}, 32'b100);

        run_burst(3, 2, -1, 1'b0, -1);
        run_burst(1, 1, -1, 1'b0, -1);
        run_burst(0, $urandom_range(0, 255), -1, 1'b0, -1);
        run_burst($urandom_range(1, 1023), 0, -1, 1'b0, -1);
        run_burst(4, 3, 50, 1'b1, -1);
        run_burst(5, 4, -1, 1'b0, 120);
        run_burst(5, 4, -1, 1'b0, -1);
        run_burst(2, 1, -1, 1'b0, -1);
        run_burst(2, 1, -1, 1'b0, -1);
        run_burst(1023, 1, 7000, 1'b0, -1);
        run_burst(1, 255, 3000, 1'b1, -1);
        for (int r = 0; r < 8; r++) begin
            int p;
            int c;
            p = $urandom_range(1, 6);
            c = $urandom_range(1, 4);
            run_burst(p, c, $urandom_range(0, 2 * p * HALF_MS * c - 1),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
